// File: rtl/working_time_accumulator.sv
// working_time_accumulator
// Accumulates cumulative motor-on time as hours:minutes:seconds from the
// system clock. The value saturates at HOUR_MAX:59:59 instead of wrapping, so
// the cleaning reminder cannot be masked by a missed clean. It is cleared only
// by a confirmed manual clean while the hood is idle in standby.
module working_time_accumulator #(
  parameter int TICKS_PER_SEC = 100,
  parameter int HOUR_MAX      = 63
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic       is_working,
  input  logic       is_standby,
  input  logic       clean_done,
  output logic [5:0] working_hour,
  output logic [5:0] working_min,
  output logic [5:0] working_sec,
  output logic       sec_tick,
  output logic       saturated,
  output logic [1:0] run_state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    HOUR_LAST  = 6'(HOUR_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] presc_q;

  logic clear;    // accepted manual-clean event
  logic advance;  // prescaler moves this edge
  logic wrap;     // prescaler completes a second this edge
  logic sat_hit;  // this second lands on HOUR_MAX:59:59

  // A clean_done that misses the qualifier is simply dropped.
  assign clear   = clean_done & is_standby & ~is_working;
  assign advance = is_working & (state_q != ST_SAT);
  assign wrap    = advance & (presc_q == PRESC_LAST);
  assign sat_hit = wrap & (working_hour == HOUR_LAST) &
                   (working_min == 6'd59) & (working_sec == 6'd58);

  // State register.
  always_ff @(posedge clk_100Hz) begin
    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block
    // and is absent from the sensitivity list.
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, whatever the statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic: clear beats the saturating second, which beats the
  // ordinary run/idle tracking of is_working.
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (sat_hit)         state_d = ST_SAT;
          else if (is_working) state_d = ST_RUN;
          else                 state_d = ST_IDLE;
        end
        ST_SAT:  state_d = ST_SAT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler and h:m:s cascade; the prescaler holds while the motor is off
  // so partial seconds carry over to the next run.
  always_ff @(posedge clk_100Hz) begin
    if (!rst_n) begin
      presc_q      <= '0;
      working_hour <= '0;
      working_min  <= '0;
      working_sec  <= '0;
      sec_tick     <= 1'b0;
    end else if (clear) begin
      presc_q      <= '0;
      working_hour <= '0;
      working_min  <= '0;
      working_sec  <= '0;
      sec_tick     <= 1'b0;
    end else begin
      sec_tick <= wrap;
      if (advance) begin
        presc_q <= wrap ? '0 : presc_q + 1'b1;
      end
      if (wrap) begin
        if (working_sec == 6'd59) begin
          working_sec <= '0;
          if (working_min == 6'd59) begin
            working_min  <= '0;
            // Cannot pass HOUR_MAX: the second that reaches HOUR_MAX:59:59
            // freezes the counter in SAT.
            working_hour <= working_hour + 6'd1;
          end else begin
            working_min <= working_min + 6'd1;
          end
        end else begin
          working_sec <= working_sec + 6'd1;
        end
      end
    end
  end

  assign saturated = (state_q == ST_SAT);
  assign run_state = state_q;

endmodule

// File: doc/working_time_accumulator.md
# working_time_accumulator

- Accumulates the hood's cumulative motor-on time as hours:minutes:seconds from the 100 Hz system clock.
- Feeds `working_hour`/`working_min`/`working_sec` directly to the downstream cleaning-reminder comparator.
- Clears only on a confirmed manual-clean event while in standby.
- Saturates at 63:59:59 rather than wrapping, so a missed clean never masks the reminder.

## Interface
Parameters
- `TICKS_PER_SEC`, 100: clock cycles per counted second; prescaler counts 0..TICKS_PER_SEC-1.
- `HOUR_MAX`, 63: saturation hour value; the hour field width is fixed at 6 bits.

Ports
- `clk_100Hz`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `is_working`  in  1  motor running (any extraction level); counting qualifier.
- `is_standby`  in  1  top FSM in standby; gates clear acceptance.
- `clean_done`  in  1  one-cycle pulse from the clean-confirm key path.
- `working_hour`  out  6  accumulated hours, 0..HOUR_MAX.
- `working_min`  out  6  accumulated minutes, 0..59.
- `working_sec`  out  6  accumulated seconds, 0..59.
- `sec_tick`  out  1  one-cycle pulse, registered with each seconds increment.
- `saturated`  out  1  high while the time is held at HOUR_MAX:59:59.
- `run_state`  out  2  FSM state for debug/display: 0 IDLE, 1 RUN, 2 SAT.

## Operation
- **Reset** (rst_n=0 on an edge): hour/min/sec=0, prescaler=0, sec_tick=0, saturated=0, state=IDLE.
- **Clear accept**: `clear = clean_done & is_standby & ~is_working`.
  - Clears hour/min/sec and prescaler, drops saturated, and sends the FSM to IDLE.
  - A clean_done not meeting the qualifier is dropped; it is not remembered.
- **Prescaler**:
  - Advances only on edges where is_working=1 and state≠SAT.
  - At TICKS_PER_SEC-1 it wraps to 0 and issues an increment.
  - When is_working drops, the prescaler holds, so partial seconds are retained.
- **Increment cascade**:
  - sec 59→0 carries to min.
  - min 59→0 carries to hour.
  - Hour never wraps.
- **Saturation**: an increment that lands on HOUR_MAX:59:59 sets saturated=1 and state=SAT. In SAT, prescaler and time are frozen regardless of is_working.
- **FSM**:
  - IDLE→RUN when is_working=1.
  - RUN→IDLE when is_working=0.
  - RUN→SAT on the saturating increment.
  - SAT→IDLE only on clear.
  - Any state→IDLE on clear.
- **Priority** on one edge: reset > clear > increment > hold. A clear coinciding with a prescaler wrap yields 0:00:00 and sec_tick=0.
- **Range**: outputs never leave their stated ranges; min and sec never reach 60.

## Timing
- is_working is sampled on the same edge that advances the prescaler; there is no input pipeline.
- The first second completes TICKS_PER_SEC edges after is_working first rises from a zero prescaler. Example: rise before edge 1, seconds=1 after edge 100.
- sec_tick and the new time values appear on the same edge; sec_tick is high for exactly one cycle.
- Clear takes effect on the edge where the qualifier is true; outputs read 0 the following cycle.
- The downstream comparator sees time changes with one register delay; no handshake is required.
- Reset mid-count discards the prescaler residue.

## Test plan
- **Basic count**: reset, then is_working=1 for 100 edges → sec=1, sec_tick one cycle. After 6000 edges → 0:01:00.
- **Partial retention**: is_working high 60 edges, low 500 edges, high 40 edges → sec=1 exactly on the 100th working edge, 0 before.
- **Carry chain**: force-preload 0:59:59 by counting, then one more second → 1:00:00 in one edge, no intermediate 0:60:xx value.
- **Saturation**:
  - Count to 63:59:58 with is_working=1, then 100 more edges → 63:59:59, saturated=1, run_state=2.
  - A further 1000 edges leave values unchanged with no sec_tick.
- **Clear gating**:
  - clean_done with is_standby=0 → no change.
  - clean_done with is_standby=1, is_working=1 → no change.
  - clean_done with is_standby=1, is_working=0 → 0:00:00, saturated=0, run_state=0 next cycle.
- **Collision and reset**:
  - Accepted clear on the prescaler-wrap edge → 0:00:00, sec_tick=0.
  - rst_n=0 for one edge at 2:10:30 → all outputs 0 next cycle.
